// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences each instruction over 3-5 cycles with a bounded memory wait.
// Optional build macro ILLEGAL_OP_TRAP_EN: undefined opcodes enter a sticky TRAP state instead of retiring as NOPs.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op_code,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       reg_write,
    output logic [1:0] alu_src_A,
    output logic [1:0] alu_src_B,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic       LD_ST_op,
    output logic       instr_done,
    output logic       bus_error,
    output logic       illegal_op
);

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_I      = 7'd19;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_AUIPC  = 7'd23;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC_R, S_EXEC_I,
        S_ALU_WB, S_BRANCH, S_JALR, S_JMP, S_LUI, S_AUIPC, S_FAULT
`ifdef ILLEGAL_OP_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_timeout;

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            OP_STORE:          imm_of = 3'b001;
            OP_BRANCH:         imm_of = 3'b010;
            OP_JAL:            imm_of = 3'b011;
            OP_LUI, OP_AUIPC:  imm_of = 3'b100;
            default:           imm_of = 3'b000;
        endcase
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
            default:                          is_legal = 1'b0;
        endcase
    endfunction

    // The access faults on the cycle its wait count would reach MEM_TIMEOUT; ready wins in that cycle.
    assign w_timeout = (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default first, otherwise a latch is inferred.
        w_next = r_state;
        case (r_state)
            S_FETCH:   if (mem_ready) w_next = S_DECODE; else if (w_timeout) w_next = S_FAULT;
            S_DECODE: begin
                case (op_code)
                    OP_LOAD, OP_STORE: w_next = S_MEM_ADR;
                    OP_R:              w_next = S_EXEC_R;
                    OP_I:              w_next = S_EXEC_I;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JMP;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
                    OP_AUIPC:          w_next = S_AUIPC;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:           w_next = S_TRAP;
`else
                    default:           w_next = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADR: w_next = (op_code == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  if (mem_ready) w_next = S_MEM_WB; else if (w_timeout) w_next = S_FAULT;
            S_MEM_WR:  if (mem_ready) w_next = S_FETCH; else if (w_timeout) w_next = S_FAULT;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_LUI: w_next = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_JMP, S_AUIPC:  w_next = S_ALU_WB;
            S_JALR:    w_next = S_JMP;
            S_FAULT:   w_next = S_FAULT;
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP:    w_next = S_TRAP;
`endif
            default:   w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next;
            if (w_next != r_state || mem_ready)
                r_cnt <= '0;
            else if (mem_req)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        alu_src_A  = 2'b00;
        alu_src_B  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        imm_src    = 3'b000;
        LD_ST_op   = 1'b0;
        instr_done = 1'b0;
        bus_error  = 1'b0;
        illegal_op = 1'b0;
        // NOTE: rst gates the decode combinationally so no enable can pulse while reset is held.
        if (!rst) begin
            imm_src = imm_of(op_code);
            case (r_state)
                S_FETCH: begin
                    imm_src    = 3'b000;
                    mem_req    = 1'b1;
                    alu_src_B  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_A = 2'b01;
                    alu_src_B = 2'b01;
`ifndef ILLEGAL_OP_TRAP_EN
                    instr_done = !is_legal(op_code);
`endif
                end
                S_MEM_ADR: begin
                    alu_src_A = 2'b10;
                    alu_src_B = 2'b01;
                    LD_ST_op  = 1'b1;
                end
                S_MEM_RD: begin
                    mem_req  = 1'b1;
                    adr_src  = 1'b1;
                    LD_ST_op = 1'b1;
                end
                S_MEM_WB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req    = 1'b1;
                    mem_write  = 1'b1;
                    adr_src    = 1'b1;
                    LD_ST_op   = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXEC_R: begin
                    alu_src_A = 2'b10;
                    alu_op    = 2'b10;
                end
                S_EXEC_I: begin
                    alu_src_A = 2'b10;
                    alu_src_B = 2'b01;
                    alu_op    = 2'b10;
                end
                S_ALU_WB, S_LUI: begin
                    result_src = (r_state == S_LUI) ? 2'b11 : 2'b00;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_A  = 2'b10;
                    alu_op     = 2'b01;
                    branch     = 1'b1;
                    instr_done = 1'b1;
                end
                S_JALR, S_AUIPC: begin
                    alu_src_A = (r_state == S_JALR) ? 2'b10 : 2'b01;
                    alu_src_B = 2'b01;
                end
                S_JMP: begin
                    pc_write  = 1'b1;
                    alu_src_A = 2'b01;
                    alu_src_B = 2'b10;
                end
                S_FAULT: begin
                    imm_src   = 3'b000;
                    bus_error = 1'b1;
                end
`ifdef ILLEGAL_OP_TRAP_EN
                S_TRAP: begin
                    imm_src    = 3'b000;
                    illegal_op = 1'b1;
                end
`endif
                default: imm_src = 3'b000;
            endcase
        end
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle control unit for the RV32I core: a Moore FSM that sequences each instruction over 3–5 cycles and drives the shared-ALU datapath. It handles the ten base opcode classes: R, I-ALU, load, store, branch, JAL, JALR, LUI, AUIPC, and illegal. It replaces the single-cycle opcode decoder. Instruction fetch and data access share one memory through a req/ready handshake with a bounded wait; a stall past the bound is reported as a bus fault.

## Interface
- MEM_TIMEOUT, 15: maximum wait cycles with `mem_req` high and `mem_ready` low before the controller faults; must be ≥1.
- CNT_W, $clog2(MEM_TIMEOUT+1): wait-counter width (derived; do not override).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- op_code  in  7  IR[6:0]; stable from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  store access (valid with `mem_req`).
- adr_src  out  1  0 = PC, 1 = ALUOut.
- ir_write  out  1  IR load enable.
- pc_write  out  1  unconditional PC load.
- branch  out  1  conditional PC load; the datapath gates it with the compare flag.
- reg_write  out  1  register-file write enable.
- alu_src_A  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- alu_src_B  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- alu_op  out  2  00 = add, 01 = compare, 10 = funct-decoded.
- result_src  out  2  00 = ALUOut, 01 = read data, 10 = ALUResult, 11 = imm.
- imm_src  out  3  immediate format: I = 000, S = 001, B = 010, J = 011, U = 100.
- LD_ST_op  out  1  a load/store address is being formed.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- bus_error  out  1  sticky memory-timeout fault.
- illegal_op  out  1  sticky illegal-opcode flag (only when the macro is enabled).

## Operation
- States: FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JALR, JMP, LUI, AUIPC, FAULT, plus TRAP when the macro is enabled.
- Outputs are Moore functions of state. The only exception is that `ir_write`/`pc_write` in FETCH and the exits from FETCH/MEM_RD/MEM_WR are qualified by `mem_ready`.
- Any output not listed for a state is 0.
- `imm_src` is decoded from `op_code` in every state except FETCH, where it is 000.

**State behaviour**
- FETCH
  - Drives mem_req=1, adr_src=0, A=00, B=10, alu_op=00, result_src=10.
  - When `mem_ready`=1: ir_write=1, pc_write=1, go to DECODE.
- DECODE
  - Drives A=01, B=01, alu_op=00, forming the branch/JAL target in ALUOut.
  - Next state by opcode: 3/35 → MEM_ADR; 51 → EXEC_R; 19 → EXEC_I; 99 → BRANCH; 111 → JMP; 103 → JALR; 55 → LUI; 23 → AUIPC; otherwise see Configuration.
- MEM_ADR
  - Drives A=10, B=01, alu_op=00, LD_ST_op=1.
  - Goes to MEM_RD for a load (op 3) or MEM_WR for a store (op 35).
- MEM_RD
  - Drives mem_req=1, adr_src=1, LD_ST_op=1.
  - When `mem_ready`=1: go to MEM_WB.
- MEM_WB
  - Drives result_src=01, reg_write=1, instr_done=1; then FETCH.
- MEM_WR
  - Drives mem_req=1, mem_write=1, adr_src=1, LD_ST_op=1.
  - When `mem_ready`=1: instr_done=1, go to FETCH.
- EXEC_R
  - Drives A=10, B=00, alu_op=10; then ALU_WB.
- EXEC_I
  - Drives A=10, B=01, alu_op=10; then ALU_WB.
- ALU_WB
  - Drives result_src=00, reg_write=1, instr_done=1; then FETCH.
- BRANCH
  - Drives A=10, B=00, alu_op=01, result_src=00, branch=1, instr_done=1; then FETCH.
- JALR
  - Drives A=10, B=01, alu_op=00; then JMP.
- JMP
  - Drives pc_write=1, result_src=00, A=01, B=10, alu_op=00, putting OldPC+4 in ALUOut; then ALU_WB.
- LUI
  - Drives result_src=11, reg_write=1, instr_done=1; then FETCH.
- AUIPC
  - Drives A=01, B=01, alu_op=00; then ALU_WB.
- FAULT
  - All outputs 0 except `bus_error`=1.
  - Terminal state until `rst`.

**Memory wait counter**
- The counter is cleared on entry to FETCH, MEM_RD and MEM_WR, and whenever `mem_ready`=1.
- It increments each cycle that mem_req=1 and mem_ready=0.
- When it reaches MEM_TIMEOUT with `mem_ready` still 0, the next state is FAULT.
- If `mem_ready` arrives in that same cycle, the access completes normally; ready has priority over timeout.

## Timing
- While `rst`=1: state=FETCH, counter=0, `bus_error`=`illegal_op`=0, and all outputs are forced to 0.
- After release, FETCH drives `mem_req` from the first clock.
- A reset asserted mid-instruction aborts it immediately. No write-enable may glitch high while `rst`=1.

**Latency with zero-wait memory (mem_ready=1 on the first request cycle)**

| Instruction | Cycles |
|---|---|
| R, I-ALU, store, JAL, AUIPC | 4 |
| load, JALR | 5 |
| branch, LUI | 3 |

- Each cycle of `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- `instr_done` is asserted exactly once per retired instruction, in its last cycle.

## Configuration
- `ILLEGAL_OP_TRAP_EN` defined:
  - An undefined opcode in DECODE goes to TRAP.
  - TRAP holds all outputs 0 except `illegal_op`=1, and stays there until `rst`.
- `ILLEGAL_OP_TRAP_EN` not defined:
  - An undefined opcode is retired as a NOP: DECODE → FETCH with `instr_done`=1.
  - `illegal_op` is tied to 0.

## Test plan
- R-type (op 51), mem_ready always 1 → states FETCH, DECODE, EXEC_R, ALU_WB. `reg_write`=1 only in cycle 4; `instr_done` pulses once, in cycle 4.
- Load (op 3) with mem_ready low for 2 cycles in MEM_RD → 7 cycles total. `LD_ST_op`=1 in MEM_ADR/MEM_RD. `result_src`=01 with reg_write=1 in MEM_WB.
- JAL (op 111) then JALR (op 103) → 4 and 5 cycles respectively. `pc_write`=1 in FETCH and JMP; ALU_WB writes with result_src=00.
- Branch (op 99) → 3 cycles. branch=1, alu_op=01, A=10, B=00 in cycle 3; `pc_write`=0 throughout after FETCH.
- MEM_TIMEOUT=3, mem_ready held 0 in FETCH → FAULT entered after 3 wait cycles; `bus_error` sticky. Asserting rst mid-FETCH clears it and returns to FETCH.
- Opcode 0x7F: with `ILLEGAL_OP_TRAP_EN` → TRAP, `illegal_op`=1 held. Without it → 2-cycle NOP with `instr_done`=1 and the next fetch follows.
